// File: rtl/flappy_pkg.sv
// flappy_pkg: shared game-state/coin-state enums and coin sprite size
package flappy_pkg;
  typedef enum logic [1:0] {READY = 2'd0, PLAY = 2'd1, OVER = 2'd2} game_state_t;
  typedef enum logic {LIVE = 1'b0, TAKEN = 1'b1} coin_state_t;
  localparam int COIN_SIZE = 16;
endpackage

// File: rtl/coin_collect_ctrl_if.sv
// coin_collect_ctrl_if: frame_clk, game_state and bird/coin positions in; collected flags, coin_count and coin_pulse out
interface coin_collect_ctrl_if;
  logic       frame_clk;
  logic [1:0] game_state;
  logic [9:0] bird_X_Pos, bird_Y_Pos;
  logic [9:0] coin1_X_Pos, coin1_Y_Pos, coin2_X_Pos, coin2_Y_Pos;
  logic       coin1_collected, coin2_collected;
  logic [9:0] coin_count;
  logic       coin_pulse;
  modport master (
    output frame_clk, game_state, bird_X_Pos, bird_Y_Pos,
           coin1_X_Pos, coin1_Y_Pos, coin2_X_Pos, coin2_Y_Pos,
    input  coin1_collected, coin2_collected, coin_count, coin_pulse
  );
  modport slave (
    input  frame_clk, game_state, bird_X_Pos, bird_Y_Pos,
           coin1_X_Pos, coin1_Y_Pos, coin2_X_Pos, coin2_Y_Pos,
    output coin1_collected, coin2_collected, coin_count, coin_pulse
  );
endinterface

// File: rtl/coin_slot_fsm.sv
// coin_slot_fsm: one coin's LIVE/TAKEN state; ports Clk, Reset, tick, play, clear, bird/coin position in; collected, take_event out
module coin_slot_fsm
  import flappy_pkg::*;
#(
  parameter int BIRD_W = 34,
  parameter int BIRD_H = 24
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       tick,
  input  logic       play,
  input  logic       clear,
  input  logic [9:0] bird_x,
  input  logic [9:0] bird_y,
  input  logic [9:0] coin_x,
  input  logic [9:0] coin_y,
  output logic       collected,
  output logic       take_event
);
  coin_state_t state;
  logic [9:0]  prev_x;
  logic [10:0] bx, by, cx, cy;
  logic        overlap, respawn;
  assign bx = {1'b0, bird_x};
  assign by = {1'b0, bird_y};
  assign cx = {1'b0, coin_x};
  assign cy = {1'b0, coin_y};
  assign overlap = (bx < cx + 11'(COIN_SIZE)) && (cx < bx + 11'(BIRD_W)) &&
                   (by < cy + 11'(COIN_SIZE)) && (cy < by + 11'(BIRD_H));
  // a coin that jumped right has respawned; prev_x resets high so no false respawn
  assign respawn = coin_x > prev_x;
  // respawn beats overlap in the same tick
  assign take_event = tick & play & (state == LIVE) & overlap & ~respawn;
  assign collected = state == TAKEN;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= LIVE;
      prev_x <= '1;
    end else begin
      if (tick & (play | clear)) prev_x <= coin_x;
      if (clear || (tick && play && respawn)) state <= LIVE;
      else if (take_event) state <= TAKEN;
    end
  end
endmodule

// File: rtl/coin_collect_ctrl.sv
// coin_collect_ctrl: frame-tick coin collection; ports Clk, Reset, bus (slave: frame_clk/game_state/positions in, flags/count/pulse out)
module coin_collect_ctrl
  import flappy_pkg::*;
#(
  parameter int BIRD_W    = 34,
  parameter int BIRD_H    = 24,
  parameter int MAX_COUNT = 999
) (
  input logic                 Clk,
  input logic                 Reset,
  coin_collect_ctrl_if.slave  bus
);
  logic        frame_sync, frame_clk_delayed, tick;
  logic        play, clear, take1, take2, pulse;
  logic [9:0]  count;
  logic [10:0] sum;
  assign play  = bus.game_state == PLAY;
  assign clear = bus.game_state == READY;
  // frame_clk is asynchronous: one sampling flop, then rising-edge detect
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_sync        <= 1'b0;
      frame_clk_delayed <= 1'b0;
      tick              <= 1'b0;
    end else begin
      frame_sync        <= bus.frame_clk;
      frame_clk_delayed <= frame_sync;
      tick              <= frame_sync & ~frame_clk_delayed;
    end
  end
  coin_slot_fsm #(.BIRD_W(BIRD_W), .BIRD_H(BIRD_H)) u_coin1 (
    .Clk(Clk), .Reset(Reset), .tick(tick), .play(play), .clear(clear),
    .bird_x(bus.bird_X_Pos), .bird_y(bus.bird_Y_Pos),
    .coin_x(bus.coin1_X_Pos), .coin_y(bus.coin1_Y_Pos),
    .collected(bus.coin1_collected), .take_event(take1)
  );
  coin_slot_fsm #(.BIRD_W(BIRD_W), .BIRD_H(BIRD_H)) u_coin2 (
    .Clk(Clk), .Reset(Reset), .tick(tick), .play(play), .clear(clear),
    .bird_x(bus.bird_X_Pos), .bird_y(bus.bird_Y_Pos),
    .coin_x(bus.coin2_X_Pos), .coin_y(bus.coin2_Y_Pos),
    .collected(bus.coin2_collected), .take_event(take2)
  );
  assign sum = {1'b0, count} + 11'(take1) + 11'(take2);
  always_ff @(posedge Clk) begin
    if (Reset || clear) begin
      count <= '0;
      pulse <= 1'b0;
    end else if (tick && play) begin
      count <= (sum > 11'(MAX_COUNT)) ? 10'(MAX_COUNT) : sum[9:0];
      pulse <= take1 | take2;
    end else begin
      pulse <= 1'b0;
    end
  end
  assign bus.coin_count = count;
  assign bus.coin_pulse = pulse;
endmodule
